multi_band_scaler: RTL and testbench

MULTI_BAND_SCALER -- requirements
Module: multi_band_scaler

---
 rtl/multi_band_scaler.sv | 196 +++++++++++++++++++
 tb/tb_multi_band_scaler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_band_scaler.sv
// multi_band_scaler: per-band pot-controlled gain stage with a single time-shared
// multiplier, per-band saturation and a saturated sum of all bands.
// Gain follows a square-law pot curve: gain = pot^2 >> POT_W, unity at pot = 2^(POT_W-1).
// Optional feature macro: BAND_SCALE_SMOOTH_EN adds per-band gain slew limiting
// (at most SLEW change per sample set). Without it the target gain is used directly.
module multi_band_scaler #(
  parameter int NUM_BANDS = 5,
  parameter int AUD_W     = 16,
  parameter int POT_W     = 12,
  parameter int SLEW      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BANDS*POT_W-1:0]   pot,
  input  logic [NUM_BANDS*AUD_W-1:0]   audio_in,
  input  logic                         in_vld,
  output logic                         busy,
  output logic                         out_vld,
  output logic [NUM_BANDS*AUD_W-1:0]   scaled,
  output logic [AUD_W-1:0]             sum_out,
  output logic                         overrun
);

  localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int ACC_W  = AUD_W + $clog2(NUM_BANDS);
  localparam int PROD_W = AUD_W + POT_W + 1;
  localparam int SQ_W   = 2 * POT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);
  localparam logic signed [AUD_W-1:0] MAX_POS = {1'b0, {(AUD_W-1){1'b1}}};
  localparam logic signed [AUD_W-1:0] MAX_NEG = {1'b1, {(AUD_W-1){1'b0}}};

  // Reject parameter sets the datapath is not sized for.
  if (NUM_BANDS < 1 || NUM_BANDS > 16 || POT_W < 4 || SLEW < 1) begin : g_param_check
    $error("multi_band_scaler: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SQ, MUL, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [POT_W-1:0]        pot_q    [NUM_BANDS];
  logic signed [AUD_W-1:0] aud_q    [NUM_BANDS];
  logic signed [AUD_W-1:0] scaled_q [NUM_BANDS];
  logic [IDX_W-1:0]        idx;
  logic [POT_W-1:0]        gain;
  logic signed [ACC_W-1:0] acc;

  logic [POT_W-1:0]        pot_sel;
  logic signed [AUD_W-1:0] aud_sel;
  logic [SQ_W-1:0]         pot_sq;
  logic [POT_W-1:0]        tgt;
  logic [POT_W-1:0]        gain_nxt;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] aud_ext;
  logic signed [PROD_W-1:0] prod;
  logic [3:0]              prod_top;
  logic signed [AUD_W-1:0] prod_sat;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [ACC_W-AUD_W:0]    acc_top;
  logic signed [AUD_W-1:0] sum_sat;
  logic                    unused_bits;

  assign busy = (state != IDLE);

  // State register; reset abandons any set in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: two cycles per band, then one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_vld) state_nxt = SQ;
      SQ:      state_nxt = MUL;
      MUL:     state_nxt = (idx == LAST_IDX) ? DONE : SQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Band select and square-law target gain for the current band.
  always_comb begin
    pot_sel = pot_q[idx];
    aud_sel = aud_q[idx];
    pot_sq  = SQ_W'(pot_sel) * SQ_W'(pot_sel);
    tgt     = pot_sq[SQ_W-1:POT_W];
  end

`ifdef BAND_SCALE_SMOOTH_EN
  localparam logic [POT_W-1:0] SLEW_V = POT_W'(SLEW);

  logic [POT_W-1:0] g_q [NUM_BANDS];
  logic [POT_W-1:0] g_cur;
  logic [POT_W-1:0] g_diff;

  // Step the band's smoothed gain toward the target, limited to SLEW.
  always_comb begin
    g_cur    = g_q[idx];
    g_diff   = '0;
    gain_nxt = g_cur;
    if (tgt > g_cur) begin
      g_diff   = tgt - g_cur;
      gain_nxt = g_cur + ((g_diff > SLEW_V) ? SLEW_V : g_diff);
    end else begin
      g_diff   = g_cur - tgt;
      gain_nxt = g_cur - ((g_diff > SLEW_V) ? SLEW_V : g_diff);
    end
  end

  // Smoothed gain memory, one entry per band, updated once per set in SQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) g_q[i] <= '0;
    end else if (state == SQ) begin
      g_q[idx] <= gain_nxt;
    end
  end
`else
  // Without smoothing the target gain is applied immediately.
  always_comb begin
    gain_nxt = tgt;
  end
`endif

  // Shared multiplier, product saturation and accumulator/sum saturation.
  always_comb begin
    gain_ext = PROD_W'({1'b0, gain});
    aud_ext  = PROD_W'(aud_sel);
    prod     = gain_ext * aud_ext;
    prod_top = prod[PROD_W-1:PROD_W-4];
    if (&prod_top || ~|prod_top) prod_sat = prod[AUD_W+POT_W-3:POT_W-2];
    else                         prod_sat = prod[PROD_W-1] ? MAX_NEG : MAX_POS;
    acc_nxt  = acc + ACC_W'(prod_sat);
    acc_top  = acc[ACC_W-1:AUD_W-1];
    if (&acc_top || ~|acc_top) sum_sat = acc[AUD_W-1:0];
    else                       sum_sat = acc[ACC_W-1] ? MAX_NEG : MAX_POS;
  end

  // Fraction bits dropped by the fixed-point scaling.
  assign unused_bits = ^{prod[POT_W-3:0], pot_sq[POT_W-1:0]};

  // Datapath registers: input latch, band index, gain, results and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        pot_q[i]    <= '0;
        aud_q[i]    <= '0;
        scaled_q[i] <= '0;
      end
      idx     <= '0;
      gain    <= '0;
      acc     <= '0;
      sum_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
              pot_q[i] <= pot[i*POT_W +: POT_W];
              aud_q[i] <= audio_in[i*AUD_W +: AUD_W];
            end
            idx <= '0;
            acc <= '0;
          end
        end
        SQ: gain <= gain_nxt;
        MUL: begin
          scaled_q[idx] <= prod_sat;
          acc           <= acc_nxt;
          if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        end
        DONE: sum_out <= sum_sat;
        default: ;
      endcase
    end
  end

  // Completion pulse and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      overrun <= 1'b0;
    end else begin
      out_vld <= (state == DONE);
      if (in_vld && state != IDLE) overrun <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_BANDS; i++) begin : g_pack
    assign scaled[i*AUD_W +: AUD_W] = scaled_q[i];
  end

endmodule

// File: tb/tb_multi_band_scaler.sv
// tb_multi_band_scaler: directed-vector bench for multi_band_scaler with a
// behavioural reference model checked every cycle, plus literal expectations.
// Builds with or without BAND_SCALE_SMOOTH_EN.
module tb_multi_band_scaler;

  localparam int NB    = 5;
  localparam int AW    = 16;
  localparam int PW    = 12;
  localparam int SLEW  = 16;
  localparam int SHIFT = PW - 2;
  localparam longint PROD_LIM = longint'(1) << (AW + PW - 3);
  localparam int AMAX  = (1 << (AW - 1)) - 1;
  localparam int AMIN  = -(1 << (AW - 1));

  logic               clk      = 1'b0;
  logic               rst      = 1'b1;
  logic [NB*PW-1:0]   pot      = '0;
  logic [NB*AW-1:0]   audio_in = '0;
  logic               in_vld   = 1'b0;
  logic               busy;
  logic               out_vld;
  logic [NB*AW-1:0]   scaled;
  logic [AW-1:0]      sum_out;
  logic               overrun;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int m_cnt = 0;
  int m_band = 0;
  int pend_scaled [NB];
  int pend_sum = 0;
  int exp_scaled [NB];
  int exp_sum = 0;
  bit exp_vld = 1'b0;
  bit exp_ovr = 1'b0;
`ifdef BAND_SCALE_SMOOTH_EN
  int m_g [NB];
`endif

  multi_band_scaler #(
    .NUM_BANDS(NB), .AUD_W(AW), .POT_W(PW), .SLEW(SLEW)
  ) dut (
    .clk(clk), .rst(rst), .pot(pot), .audio_in(audio_in), .in_vld(in_vld),
    .busy(busy), .out_vld(out_vld), .scaled(scaled), .sum_out(sum_out),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int s16(logic [AW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clamp(int v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  // Scaled band value from gain and sample, by range rather than bit slicing.
  function automatic int band_result(int g, int a);
    longint prod;
    prod = longint'(g) * longint'(a);
    if (prod >= PROD_LIM) return AMAX;
    if (prod < -PROD_LIM) return AMIN;
    return int'(prod >>> SHIFT);
  endfunction

  function automatic void check_output(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endfunction

  function automatic void check_band(string tag, int i, int want);
    check_output($sformatf("%s_band%0d", tag, i), s16(scaled[i*AW +: AW]), want);
  endfunction

  // Compute a whole set's results at capture time.
  function automatic void model_capture();
    int p, a, t, g, s, d;
    s = 0;
    for (int i = 0; i < NB; i++) begin
      p = int'(pot[i*PW +: PW]);
      a = int'($signed(audio_in[i*AW +: AW]));
      t = (p * p) >> PW;
`ifdef BAND_SCALE_SMOOTH_EN
      d = t - m_g[i];
      if (d > SLEW)  d = SLEW;
      if (d < -SLEW) d = -SLEW;
      m_g[i] = m_g[i] + d;
      g = m_g[i];
`else
      d = 0;
      g = t + d;
`endif
      pend_scaled[i] = band_result(g, a);
      s += pend_scaled[i];
    end
    pend_sum = clamp(s);
  endfunction

  // Model timeline: band i appears 2i+2 edges after capture, sum and pulse at 2N+1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   = 0;
      exp_vld = 1'b0;
      exp_ovr = 1'b0;
      exp_sum = 0;
      for (int i = 0; i < NB; i++) begin
        exp_scaled[i] = 0;
`ifdef BAND_SCALE_SMOOTH_EN
        m_g[i] = 0;
`endif
      end
    end else if (m_cnt > 0) begin
      exp_vld = 1'b0;
      if (in_vld) exp_ovr = 1'b1;
      m_cnt--;
      if (m_cnt > 0 && ((2*NB + 1 - m_cnt) % 2) == 0) begin
        m_band = (2*NB + 1 - m_cnt) / 2 - 1;
        exp_scaled[m_band] = pend_scaled[m_band];
      end
      if (m_cnt == 0) begin
        exp_vld = 1'b1;
        exp_sum = pend_sum;
      end
    end else begin
      exp_vld = 1'b0;
      if (in_vld) begin
        model_capture();
        m_cnt = 2*NB + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always begin
    @(negedge clk);
    #1;
    check_output("busy", int'(busy), int'(m_cnt > 0));
    check_output("out_vld", int'(out_vld), int'(exp_vld));
    check_output("overrun", int'(overrun), int'(exp_ovr));
    check_output("sum_out", s16(sum_out), exp_sum);
    for (int i = 0; i < NB; i++) check_band("model", i, exp_scaled[i]);
  end

  task automatic scribble();
    for (int i = 0; i < NB; i++) begin
      pot[i*PW +: PW]      = PW'($urandom);
      audio_in[i*AW +: AW] = AW'($urandom);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_vld) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic apply_stimulus(input logic [NB*PW-1:0] p, input logic [NB*AW-1:0] a,
                                output int lat);
    @(negedge clk);
    pot      = p;
    audio_in = a;
    in_vld   = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    scribble();
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int pulses;
    repeat (3) @(negedge clk);
    #1;
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_out_vld", int'(out_vld), 0);
    check_output("rst_overrun", int'(overrun), 0);
    check_output("rst_sum", s16(sum_out), 0);
    check_band("rst", 0, 0);
    rst = 1'b0;

`ifndef BAND_SCALE_SMOOTH_EN
    // Unity gain
    apply_stimulus({NB{12'h800}}, {NB{16'h0123}}, lat);
    check_output("unity_latency", lat, 11);
    for (int i = 0; i < NB; i++) check_band("unity", i, s16(16'h0123));
    check_output("unity_sum", s16(sum_out), s16(16'h05AF));

    // Full-scale pot: gain 0xFFE
    apply_stimulus({NB{12'hFFF}}, {16'hFFFF, 16'h0000, 16'hC000, 16'h4000, 16'h1000}, lat);
    check_output("full_latency", lat, 11);
    check_band("full", 0, s16(16'h3FF8));
    check_band("full", 1, s16(16'h7FFF));
    check_band("full", 2, s16(16'h8000));
    check_band("full", 4, s16(16'hFFFC));
    check_output("full_sum", s16(sum_out), s16(16'h3FF3));

    // Mixed pots, including zero gain and the exact negative limit
    apply_stimulus({12'h123, 12'h800, 12'hB50, 12'h400, 12'h000},
                   {16'h7FFF, 16'h8000, 16'h1234, 16'h1000, 16'h5555}, lat);
    check_band("mixed", 0, 0);
    check_band("mixed", 1, s16(16'h0400));
    check_band("mixed", 3, s16(16'h8000));

    // Sum saturation both directions
    apply_stimulus({NB{12'h800}}, {NB{16'h2000}}, lat);
    check_band("sumpos", 0, s16(16'h2000));
    check_output("sumpos_sum", s16(sum_out), s16(16'h7FFF));
    apply_stimulus({NB{12'h800}}, {NB{16'hE000}}, lat);
    check_output("sumneg_sum", s16(sum_out), s16(16'h8000));

    // Overrun: second strobe three edges after capture is ignored
    @(negedge clk);
    pot = {NB{12'h800}};
    audio_in = {NB{16'h0100}};
    in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    repeat (2) @(negedge clk);
    audio_in = {NB{16'h0777}};
    in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (out_vld) pulses++;
    end
    check_output("ovr_pulses", pulses, 1);
    check_output("ovr_flag", int'(overrun), 1);
    check_band("ovr", 0, s16(16'h0100));
    check_output("ovr_sum", s16(sum_out), s16(16'h0500));

    // Reset in the middle of a set
    @(negedge clk);
    pot = {NB{12'h800}};
    audio_in = {NB{16'h0555}};
    in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("midrst_busy", int'(busy), 0);
    check_output("midrst_out_vld", int'(out_vld), 0);
    check_output("midrst_overrun", int'(overrun), 0);
    check_output("midrst_sum", s16(sum_out), 0);
    for (int i = 0; i < NB; i++) check_band("midrst", i, 0);
    @(negedge clk);
    rst = 1'b0;
    pot = {NB{12'h800}};
    audio_in = {NB{16'h0200}};
    in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    scribble();
    wait_done(lat);
    check_output("postrst_latency", lat, 11);
    check_band("postrst", 0, s16(16'h0200));
    check_output("postrst_sum", s16(sum_out), s16(16'h0A00));
`else
    // Smoothed gain ramps by SLEW per set from zero
    for (int k = 1; k <= 64; k++) begin
      apply_stimulus({NB{12'h800}}, {NB{16'h4000}}, lat);
      check_output("smooth_latency", lat, 11);
      check_band("smooth", 0, k * 256);
    end
    check_band("smooth_final", 0, s16(16'h4000));
    apply_stimulus({NB{12'h800}}, {NB{16'h4000}}, lat);
    check_band("smooth_hold", 0, s16(16'h4000));
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
